ssd_scan_driver: RTL and testbench

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_scan_driver_if.sv | 28 ++
 rtl/ssd_hex_decoder.sv | 13 +
 rtl/ssd_scan_driver.sv | 158 +++++++++++++++
 tb/tb_ssd_scan_driver.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment scan driver.
//   seg_t       - a_to_g bit order (a = bit 6 ... g = bit 0)
//   FONT        - 16-entry hex font, active-high segments
//   SEG_POL_*   - polarity constants for segment/dp/anode drive
//   seg_drive() - applies output polarity to an active-high segment vector
package ssd_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned NIBBLE_W = 4;

    // Packed member order fixes the a_to_g bit positions: a is the MSB.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    // Hex font 0..F, active-high a..g.
    localparam logic [SEG_W-1:0] FONT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic SEG_POL_ACTIVE_LOW  = 1'b1;
    localparam logic SEG_POL_ACTIVE_HIGH = 1'b0;

    // Convert active-high segments to the pin polarity.
    function automatic logic [SEG_W-1:0] seg_drive(input logic active_low, input seg_t segs);
        logic [SEG_W-1:0] v;
        v = segs;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver_if: bus between a display client and the scan driver.
//   value/dp_in/load/lzb : client -> driver (digit data, dp enables, load strobe, blanking mode)
//   a_to_g/an/dp         : driver -> display pins
//   frame_done           : driver -> client, one-cycle pulse at start of each scan frame
interface ssd_scan_driver_if
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [NIBBLE_W*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]          dp_in;
    logic                           load;
    logic                           lzb;
    logic [SEG_W-1:0]               a_to_g;
    logic [NUM_DIGITS-1:0]          an;
    logic                           dp;
    logic                           frame_done;

    modport master (
        output value, dp_in, load, lzb,
        input  a_to_g, an, dp, frame_done
    );

    modport slave (
        input  value, dp_in, load, lzb,
        output a_to_g, an, dp, frame_done
    );
endinterface

// File: rtl/ssd_hex_decoder.sv
// ssd_hex_decoder: combinational 4-bit nibble to active-high seven-segment pattern.
//   i_nibble : hex digit 0..F
//   o_seg_c  : segments a..g, active-high, a_to_g bit order
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output seg_t                o_seg_c
);

    assign o_seg_c = seg_t'(FONT[i_nibble]);

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed hex display driver with frame-synchronous
// updates and optional leading-zero blanking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ssd_scan_driver_if
//              in : value (nibble i -> digit i), dp_in, load, lzb
//              out: a_to_g, an, dp (registered, SEG_ACTIVE_LOW polarity), frame_done
// A "wrap cycle" is the last refresh cycle of digit NUM_DIGITS-1; the display
// registers change only at the end of it, so a frame is never torn.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    ssd_scan_driver_if.slave bus
);

    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam logic        POL   = SEG_ACTIVE_LOW ? SEG_POL_ACTIVE_LOW : SEG_POL_ACTIVE_HIGH;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{POL}};
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{POL}};
    localparam logic [CNT_W-1:0]      CNT_TC  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]      DIG_TC  = DIG_W'(NUM_DIGITS - 1);

    // Scan position
    logic [CNT_W-1:0]      r_refresh;
    logic [DIG_W-1:0]      r_digit;

    // Staging and display copies of the digit data
    logic [VAL_W-1:0]      r_stage_val;
    logic [NUM_DIGITS-1:0] r_stage_dp;
    logic                  r_pending;
    logic [VAL_W-1:0]      r_disp_val;
    logic [NUM_DIGITS-1:0] r_disp_dp;

    // Pin registers
    logic [NUM_DIGITS-1:0] r_an;
    logic [SEG_W-1:0]      r_seg;
    logic                  r_dp;
    logic                  r_frame_done;

    logic                  w_tc;
    logic                  w_wrap;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_dp_sel;
    logic [DIG_W-1:0]      w_msd;
    logic                  w_blank;
    seg_t                  w_dec_seg;
    seg_t                  w_seg_ah;
    logic [NUM_DIGITS-1:0] w_an_ah;
    logic                  w_dp_ah;

    assign w_tc   = (r_refresh == CNT_TC);
    assign w_wrap = w_tc && (r_digit == DIG_TC);

    // Refresh counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (w_tc) begin
            r_refresh <= '0;
            r_digit   <= w_wrap ? '0 : r_digit + DIG_W'(1);
        end else begin
            r_refresh <= r_refresh + CNT_W'(1);
        end
    end

    // Staging / display update; a load in the wrap cycle goes straight to display
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_val <= '0;
            r_stage_dp  <= '0;
            r_pending   <= 1'b0;
            r_disp_val  <= '0;
            r_disp_dp   <= '0;
        end else if (w_wrap && bus.load) begin
            r_disp_val  <= bus.value;
            r_disp_dp   <= bus.dp_in;
            r_pending   <= 1'b0;
        end else if (w_wrap && r_pending) begin
            r_disp_val  <= r_stage_val;
            r_disp_dp   <= r_stage_dp;
            r_pending   <= 1'b0;
        end else if (bus.load) begin
            r_stage_val <= bus.value;
            r_stage_dp  <= bus.dp_in;
            r_pending   <= 1'b1;
        end
    end

    // Select the nibble and dp bit of the digit being scanned
    always_comb begin
        w_nibble = '0;
        w_dp_sel = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_digit == DIG_W'(i)) begin
                w_nibble = r_disp_val[NIBBLE_W*i +: NIBBLE_W];
                w_dp_sel = r_disp_dp[i];
            end
        end
    end

    // Highest nonzero digit; digit 0 is the floor so an all-zero value still shows "0"
    always_comb begin
        w_msd = '0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            if (r_disp_val[NIBBLE_W*i +: NIBBLE_W] != '0) begin
                w_msd = DIG_W'(i);
            end
        end
    end

    assign w_blank = bus.lzb && (r_digit > w_msd);

    ssd_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg_c  (w_dec_seg)
    );

    // Active-high pin values; a blanked digit drives nothing at all
    always_comb begin
        w_an_ah = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            w_an_ah[i] = (r_digit == DIG_W'(i)) && !w_blank;
        end
    end

    assign w_seg_ah = w_blank ? seg_t'('0) : w_dec_seg;
    assign w_dp_ah  = w_dp_sel && !w_blank;

    // Output registers, polarity applied on the way in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an         <= AN_OFF;
            r_seg        <= SEG_OFF;
            r_dp         <= POL;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= POL ? ~w_an_ah : w_an_ah;
            r_seg        <= seg_drive(POL, w_seg_ah);
            r_dp         <= POL ^ w_dp_ah;
            r_frame_done <= w_wrap;
        end
    end

    assign bus.an         = r_an;
    assign bus.a_to_g     = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: self-checking bench for ssd_scan_driver with
// NUM_DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1. The reference model tracks
// time since reset and derives digit/frame position arithmetically.
module tb_ssd_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] FONT_AH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssd_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    ssd_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_t;
    logic [15:0] m_disp, m_stage;
    logic [3:0]  m_ddp, m_sdp;
    bit          m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_fd;

    function automatic int msd(input logic [15:0] v);
        for (int i = N - 1; i > 0; i--) begin
            if (v[4*i +: 4] != 4'h0) return i;
        end
        return 0;
    endfunction

    // Advance one clock: predict the registered outputs, update the model, then sample at edge+1
    task automatic tick();
        int       d;
        bit       blank;
        logic [3:0] nib;
        if (rst) begin
            m_t = 0; m_disp = '0; m_ddp = '0; m_stage = '0; m_sdp = '0; m_pend = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            d       = (m_t / DIV) % N;
            blank   = bus.lzb && (d > msd(m_disp));
            nib     = 4'((m_disp >> (4*d)) & 16'hF);
            exp_an  = blank ? 4'hF : ~(4'b0001 << d);
            exp_seg = blank ? 7'h7F : ~FONT_AH[nib];
            exp_dp  = blank ? 1'b1 : ~m_ddp[d];
            if ((m_t % FRAME) == FRAME - 1 && bus.load) begin
                m_disp = bus.value; m_ddp = bus.dp_in; m_pend = 0;
            end else if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
                m_disp = m_stage; m_ddp = m_sdp; m_pend = 0;
            end else if (bus.load) begin
                m_stage = bus.value; m_sdp = bus.dp_in; m_pend = 1;
            end
            m_t++;
            exp_fd = (m_t % FRAME) == 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int phase);
        while ((m_t % FRAME) != phase) tick();
    endtask

    task automatic test_reset();
        int last = -1;
        rst = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF; bus.dp_in = 4'hF;
        repeat (3) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_state got=%h want=%h", {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
            end
        end
        rst = 1'b0; bus.load = 1'b0;
        tick();
        checks++;
        if (bus.an !== 4'b1110 || bus.a_to_g !== 7'h01) begin
            failures++;
            $display("FAIL first_digit got an=%b seg=%h want an=1110 seg=01", bus.an, bus.a_to_g);
        end
        for (int c = 0; c < 47; c++) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL scan t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
            if (bus.frame_done) begin
                if (last >= 0) begin
                    checks++;
                    if (m_t - last != FRAME) begin
                        failures++;
                        $display("FAIL frame_period got=%0d want=%0d", m_t - last, FRAME);
                    end
                end
                last = m_t;
            end
        end
    endtask

    task automatic test_load_midframe();
        run_to(5);
        bus.load = 1'b1; bus.value = 16'h0079; bus.dp_in = 4'b0010;
        tick();
        bus.load = 1'b0;
        while ((m_t % FRAME) != 0) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL midframe_hold t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
        end
        tick();
        checks++;
        if ({bus.an, bus.a_to_g, bus.dp} !== {4'b1110, 7'h04, 1'b1}) begin
            failures++;
            $display("FAIL midframe_digit0 got an=%b seg=%h dp=%b want an=1110 seg=04 dp=1", bus.an, bus.a_to_g, bus.dp);
        end
        repeat (DIV - 1) tick();
        tick();
        checks++;
        if ({bus.an, bus.a_to_g, bus.dp} !== {4'b1101, 7'h0F, 1'b0}) begin
            failures++;
            $display("FAIL midframe_digit1 got an=%b seg=%h dp=%b want an=1101 seg=0F dp=0", bus.an, bus.a_to_g, bus.dp);
        end
    endtask

    task automatic test_double_load();
        int seen_one = 0;
        run_to(2);
        bus.load = 1'b1; bus.value = 16'h1111; bus.dp_in = 4'h0;
        tick();
        bus.load = 1'b0;
        tick(); tick();
        bus.load = 1'b1; bus.value = 16'h2222;
        tick();
        bus.load = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL double_load t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
            if (bus.an !== 4'hF && bus.a_to_g === 7'h4F) seen_one++;
        end
        checks++;
        if (seen_one != 0) begin
            failures++;
            $display("FAIL double_load_first_shown got=%0d want=0", seen_one);
        end
    endtask

    task automatic test_lzb();
        int bad = 0;
        int lit0 = 0;
        bus.lzb = 1'b1;
        bus.load = 1'b1; bus.value = 16'h0070; bus.dp_in = 4'hF;
        tick();
        bus.load = 1'b0;
        run_to(0);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL lzb_0070 t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
            if (bus.an === 4'b1011 || bus.an === 4'b0111) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lzb_upper_lit got=%0d want=0", bad);
        end
        bus.load = 1'b1; bus.value = 16'h0000; bus.dp_in = 4'h0;
        tick();
        bus.load = 1'b0;
        run_to(0);
        bad = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (bus.an === 4'b1110 && bus.a_to_g === 7'h01) lit0++;
            else if (bus.an !== 4'hF) bad++;
        end
        checks++;
        if (bad != 0 || lit0 != 2 * DIV) begin
            failures++;
            $display("FAIL lzb_zero got bad=%0d lit0=%0d want bad=0 lit0=%0d", bad, lit0, 2 * DIV);
        end
        bus.lzb = 1'b0;
    endtask

    task automatic test_wrap_load();
        run_to(FRAME - 1);
        bus.load = 1'b1; bus.value = 16'hABCD; bus.dp_in = 4'h0;
        tick();
        bus.load = 1'b0;
        tick();
        checks++;
        if (bus.an !== 4'b1110 || bus.a_to_g !== 7'h42) begin
            failures++;
            $display("FAIL wrap_load got an=%b seg=%h want an=1110 seg=42", bus.an, bus.a_to_g);
        end
        for (int c = 0; c < FRAME; c++) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL wrap_frame t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
        end
    endtask

    task automatic test_reset_mid();
        run_to(2 * DIV + 1);
        bus.load = 1'b1; bus.value = 16'h5555; bus.dp_in = 4'hF;
        tick();
        bus.load = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got=%h want=%h", {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME + 2; c++) begin
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL after_reset t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.load  = ($urandom_range(0, 5) == 0);
            bus.value = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus.value[15:8] = 8'h00;
            bus.dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) bus.lzb = ~bus.lzb;
            tick();
            checks++;
            if ({bus.an, bus.a_to_g, bus.dp, bus.frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL random t=%0d got=%h want=%h", m_t, {bus.an, bus.a_to_g, bus.dp, bus.frame_done}, {exp_an, exp_seg, exp_dp, exp_fd});
            end
        end
        rst = 1'b0; bus.load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lzb = 1'b0;
        m_t = 0; m_disp = '0; m_stage = '0; m_ddp = '0; m_sdp = '0; m_pend = 0;
        test_reset();
        test_load_midframe();
        test_double_load();
        test_lzb();
        test_wrap_load();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
